// File: rtl/core_pkg.sv
// Shared types, constants and datapath helpers for the multi-cycle core.
// Holds the FSM state enum, ARM cond/opcode codes, shifters and the ALU.
package core_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALT
    } state_t;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  nzcv;
    } alu_out_t;

    // TST/TEQ/CMP/CMN: flags only, no Rd write
    function automatic logic is_compare(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

    function automatic logic is_arith(input logic [3:0] op);
        return (op >= OP_SUB && op <= OP_RSC) ||
               (op == OP_CMP) || (op == OP_CMN);
    endfunction

    // imm8 rotated right by twice the 4-bit rotate field
    function automatic logic [31:0] immediate_shifter(input logic [11:0] imm);
        logic [31:0] v;
        logic [5:0]  rot;
        v   = {24'd0, imm[7:0]};
        rot = {1'b0, imm[11:8], 1'b0};
        return (v >> rot) | (v << (6'd32 - rot));
    endfunction

    function automatic logic [31:0] shifter(
        input logic [31:0] v,
        input logic [1:0]  typ,
        input logic [4:0]  amt
    );
        logic [5:0]  a;
        logic [31:0] r;
        a = {1'b0, amt};
        case (typ)
            2'b00:   r = v << a;
            2'b01:   r = v >> a;
            2'b10:   r = $unsigned($signed(v) >>> a);
            default: r = (v >> a) | (v << (6'd32 - a));
        endcase
        return r;
    endfunction

    // Every arithmetic op is folded onto x + y + ci so C/V come
    // from one adder; for subtracts C is the ARM not-borrow.
    function automatic alu_out_t alu(
        input logic [3:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        cin
    );
        logic [31:0] x;
        logic [31:0] y;
        logic        ci;
        logic [32:0] s;
        logic [31:0] r;
        logic        v;
        alu_out_t    o;
        x  = a;
        y  = b;
        ci = 1'b0;
        case (op)
            OP_SUB, OP_CMP: begin y = ~b; ci = 1'b1; end
            OP_RSB:         begin x = b; y = ~a; ci = 1'b1; end
            OP_ADC:         ci = cin;
            OP_SBC:         begin y = ~b; ci = cin; end
            OP_RSC:         begin x = b; y = ~a; ci = cin; end
            default:        ci = 1'b0;
        endcase
        s = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        v = (x[31] == y[31]) && (s[31] != x[31]);
        case (op)
            OP_AND, OP_TST: r = a & b;
            OP_EOR, OP_TEQ: r = a ^ b;
            OP_ORR:         r = a | b;
            OP_MOV:         r = b;
            OP_BIC:         r = a & ~b;
            OP_MVN:         r = ~b;
            default:        r = s[31:0];
        endcase
        o.res  = r;
        o.nzcv = {r[31], (r == 32'd0), s[32], v};
        return o;
    endfunction

endpackage

// File: rtl/core_multicycle_cond.sv
// cond_check: evaluates an ARM condition field against NZCV.
// Ports: i_cond (IR[31:28]), i_nzcv {N,Z,C,V}, o_pass (execute).
module cond_check
    import core_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_nzcv,
    output logic       o_pass
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign {w_n, w_z, w_c, w_v} = i_nzcv;

    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = !w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = !w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = !w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = !w_v;
            COND_HI: o_pass = w_c && !w_z;
            COND_LS: o_pass = !w_c || w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = !w_z && (w_n == w_v);
            COND_LE: o_pass = w_z || (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            COND_NV: o_pass = 1'b0;
            default: o_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/core_multicycle.sv
// core_multicycle: FETCH/DECODE/EXECUTE/WRITEBACK ARM data-processing core
// with NZCV, condition codes and halt on undefined encodings.
// Ports: clk, reset_ni (async, active-low); imem_req_o/imem_addr_o out,
// imem_valid_i/imem_rdata_i in; flags_o {N,Z,C,V}; retired_o pulse per
// instruction; halted_o sticky halt. Macro CORE_BRANCH_EN adds B/BL.
module core_multicycle
    import core_pkg::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset_ni,
    output logic                imem_req_o,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic                imem_valid_i,
    input  logic [31:0]         imem_rdata_i,
    output logic [3:0]          flags_o,
    output logic                retired_o,
    output logic                halted_o
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_req;
    logic                w_req_nxt;
    logic [PC_WIDTH-1:0] r_pc;
    logic [31:0]         r_ir;
    logic [3:0]          r_flags;
    logic [31:0]         r_res;
    logic [3:0]          r_nzcv;
    logic                r_pass;
    logic [31:0]         r_rf [0:14];

    logic                w_ir_we;
    logic                w_ex_we;
    logic                w_wb;

    logic [3:0]          w_cond;
    logic [3:0]          w_op;
    logic                w_s;
    logic [3:0]          w_rn;
    logic [3:0]          w_rd;
    logic [3:0]          w_rs;
    logic [3:0]          w_rm;

    logic [PC_WIDTH-1:0] w_pc4;
    logic [PC_WIDTH-1:0] w_pc8;
    logic [PC_WIDTH-1:0] w_br_tgt;
    logic [PC_WIDTH-1:0] w_pc_nxt;
    logic [31:0]         w_pc_src;
    logic [31:0]         w_rn_val;
    logic [31:0]         w_rm_val;
    logic [31:0]         w_rs_val;
    logic [4:0]          w_amt;
    logic [31:0]         w_op_b;
    alu_out_t            w_alu;
    logic                w_pass;
    logic                w_is_br;
    logic                w_undef;

    logic                w_wr_rd;
    logic                w_rf_we;
    logic                w_pc_wr;
    logic                w_fl_we;
    logic                w_lr_we;

    assign w_cond = r_ir[31:28];
    assign w_op   = r_ir[24:21];
    assign w_s    = r_ir[20];
    assign w_rn   = r_ir[19:16];
    assign w_rd   = r_ir[15:12];
    assign w_rs   = r_ir[11:8];
    assign w_rm   = r_ir[3:0];

    assign w_pc4    = r_pc + PC_WIDTH'(4);
    assign w_pc8    = r_pc + PC_WIDTH'(8);
    assign w_pc_src = 32'(w_pc8);

`ifdef CORE_BRANCH_EN
    assign w_is_br  = (r_ir[27:25] == 3'b101);
    assign w_br_tgt = PC_WIDTH'(w_pc_src +
                      {{6{r_ir[23]}}, r_ir[23:0], 2'b00});
`else
    assign w_is_br  = 1'b0;
    assign w_br_tgt = w_pc4;
`endif

    assign w_undef = (r_ir[27:26] != 2'b00) && !w_is_br;

    // R15 as a source reads PC+8
    always_comb begin
        w_rn_val = (w_rn == 4'hF) ? w_pc_src : r_rf[w_rn];
        w_rm_val = (w_rm == 4'hF) ? w_pc_src : r_rf[w_rm];
        w_rs_val = (w_rs == 4'hF) ? w_pc_src : r_rf[w_rs];
    end

    assign w_amt  = r_ir[4] ? 5'(w_rs_val) : r_ir[11:7];
    assign w_op_b = r_ir[25] ? immediate_shifter(r_ir[11:0])
                             : shifter(w_rm_val, r_ir[6:5], w_amt);
    assign w_alu  = alu(w_op, w_rn_val, w_op_b, r_flags[1]);

    cond_check u_cond (
        .i_cond (w_cond),
        .i_nzcv (r_flags),
        .o_pass (w_pass)
    );

    assign w_wr_rd = w_wb && r_pass && !w_is_br && !is_compare(w_op);
    assign w_rf_we = w_wr_rd && (w_rd != 4'hF);
    assign w_pc_wr = w_wr_rd && (w_rd == 4'hF);
    assign w_fl_we = w_wb && r_pass && !w_is_br &&
                     (w_s || is_compare(w_op));
    assign w_lr_we = w_wb && r_pass && w_is_br && r_ir[24];

    always_comb begin
        w_pc_nxt = w_pc4;
        if (w_pc_wr) begin
            w_pc_nxt = PC_WIDTH'(r_res) & ~PC_WIDTH'(3);
        end else if (w_is_br && r_pass) begin
            w_pc_nxt = w_br_tgt;
        end
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_ir_we     = 1'b0;
        w_ex_we     = 1'b0;
        w_wb        = 1'b0;
        case (r_state)
            FETCH: begin
                // valid only counts once the request is visible
                if (r_req && imem_valid_i) begin
                    w_ir_we     = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = DECODE;
                end else begin
                    w_req_nxt = 1'b1;
                end
            end
            DECODE: begin
                w_state_nxt = w_undef ? HALT : EXECUTE;
            end
            EXECUTE: begin
                w_ex_we     = 1'b1;
                w_state_nxt = WRITEBACK;
            end
            WRITEBACK: begin
                w_wb        = 1'b1;
                w_req_nxt   = 1'b1;
                w_state_nxt = FETCH;
            end
            HALT: begin
                w_req_nxt = 1'b0;
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_req   <= 1'b0;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_flags <= '0;
            r_res   <= '0;
            r_nzcv  <= '0;
            r_pass  <= 1'b0;
            for (int i = 0; i < 15; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_req <= w_req_nxt;
            if (w_ir_we) begin
                r_ir <= imem_rdata_i;
            end
            if (w_ex_we) begin
                r_res  <= w_alu.res;
                r_nzcv <= w_alu.nzcv;
                r_pass <= w_pass;
            end
            if (w_wb) begin
                r_pc <= w_pc_nxt;
            end
            // logical ops keep C,V
            if (w_fl_we) begin
                r_flags <= is_arith(w_op) ? r_nzcv
                                          : {r_nzcv[3:2], r_flags[1:0]};
            end
            if (w_rf_we) begin
                r_rf[w_rd] <= r_res;
            end
            if (w_lr_we) begin
                r_rf[14] <= 32'(w_pc4);
            end
        end
    end

    assign imem_req_o  = r_req;
    assign imem_addr_o = r_pc;
    assign flags_o     = r_flags;
    assign retired_o   = (r_state == WRITEBACK);
    assign halted_o    = (r_state == HALT);

endmodule

// File: tb/tb_core_multicycle.sv
// Directed bench for core_multicycle: fetch stalls, flags, cond-fail,
// PC writes/wrap, B/BL (when CORE_BRANCH_EN) and halt/reset recovery.
module tb_core_multicycle;

    localparam int PCW = 8;

    logic           clk;
    logic           reset_ni;
    logic           imem_req_o;
    logic [PCW-1:0] imem_addr_o;
    logic           imem_valid_i;
    logic [31:0]    imem_rdata_i;
    logic [3:0]     flags_o;
    logic           retired_o;
    logic           halted_o;

    int n_tests = 0;
    int n_fail  = 0;

    core_multicycle #(
        .PC_WIDTH (PCW),
        .RESET_PC (8'h00)
    ) dut (
        .clk          (clk),
        .reset_ni     (reset_ni),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_valid_i (imem_valid_i),
        .imem_rdata_i (imem_rdata_i),
        .flags_o      (flags_o),
        .retired_o    (retired_o),
        .halted_o     (halted_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // wait (bounded) for a request, check address, hand over the word
    task automatic feed(input logic [31:0] w, input logic [31:0] a);
        int n;
        n = 0;
        while (imem_req_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_high", 32'(imem_req_o), 32'd1);
        chk("fetch_addr", 32'(imem_addr_o), a);
        imem_rdata_i = w;
        imem_valid_i = 1'b1;
        @(posedge clk);
        #1;
        imem_valid_i = 1'b0;
        imem_rdata_i = 32'hDEAD_BEEF;
    endtask

    // retired must be low in DECODE/EXECUTE, high in WRITEBACK only
    task automatic exec(input logic [31:0] w, input logic [31:0] a);
        feed(w, a);
        @(negedge clk);
        chk("ret_decode", 32'(retired_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("ret_wb", 32'(retired_o), 32'd1);
        @(posedge clk);
        #1;
        chk("ret_after", 32'(retired_o), 32'd0);
    endtask

    task automatic halt_seq(input logic [31:0] w, input logic [31:0] a);
        feed(w, a);
        @(negedge clk);
        chk("halt_decode", 32'(halted_o), 32'd0);
        @(negedge clk);
        chk("halted", 32'(halted_o), 32'd1);
        chk("halt_req", 32'(imem_req_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_req_hold", 32'(imem_req_o), 32'd0);
            chk("halt_sticky", 32'(halted_o), 32'd1);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_ni = 1'b0;
        #1;
        chk("rst_halted", 32'(halted_o), 32'd0);
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_flags", 32'(flags_o), 32'd0);
        chk("rst_addr", 32'(imem_addr_o), 32'd0);
        @(negedge clk);
        reset_ni = 1'b1;
    endtask

    initial begin
        reset_ni     = 1'b0;
        imem_valid_i = 1'b0;
        imem_rdata_i = 32'd0;
        #2;
        chk("reset_req", 32'(imem_req_o), 32'd0);
        chk("reset_ret", 32'(retired_o), 32'd0);
        chk("reset_halt", 32'(halted_o), 32'd0);
        chk("reset_flags", 32'(flags_o), 32'd0);
        chk("reset_addr", 32'(imem_addr_o), 32'd0);

        @(negedge clk);
        reset_ni = 1'b1;
        chk("req_before_edge", 32'(imem_req_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_req", 32'(imem_req_o), 32'd1);
            chk("stall_addr", 32'(imem_addr_o), 32'd0);
        end

        exec(32'hE3A01005, 32'h00);
        chk("r1_mov", dut.r_rf[1], 32'd5);
        chk("flags_mov", 32'(flags_o), 32'h0);

        exec(32'hE2512005, 32'h04);
        chk("r2_subs", dut.r_rf[2], 32'd0);
        chk("flags_subs", 32'(flags_o), 32'h6);

        exec(32'hE3A03007, 32'h08);
        chk("r3_mov", dut.r_rf[3], 32'd7);

        exec(32'hE3510006, 32'h0C);
        chk("flags_cmp6", 32'(flags_o), 32'h8);
        chk("r1_cmp_nowb", dut.r_rf[1], 32'd5);

        exec(32'hE3510005, 32'h10);
        chk("flags_cmp5", 32'(flags_o), 32'h6);

        exec(32'h13A03001, 32'h14);
        chk("r3_movne", dut.r_rf[3], 32'd7);
        chk("flags_movne", 32'(flags_o), 32'h6);

        exec(32'hE3B05102, 32'h18);
        chk("r5_movs_rot", dut.r_rf[5], 32'h8000_0000);
        chk("flags_movs", 32'(flags_o), 32'hA);

        exec(32'hE0816101, 32'h1C);
        chk("r6_add_lsl", dut.r_rf[6], 32'd25);
        chk("flags_nos", 32'(flags_o), 32'hA);

        exec(32'hE3A0F040, 32'h20);
        exec(32'hE1A0700F, 32'h40);
        chk("r7_pc8", dut.r_rf[7], 32'h48);

        exec(32'hE3A0F0FC, 32'h44);
        exec(32'hE1A00000, 32'hFC);
        exec(32'hE3A0F010, 32'h00);

`ifdef CORE_BRANCH_EN
        exec(32'hEB000002, 32'h10);
        chk("r14_bl", dut.r_rf[14], 32'h14);
        chk("flags_bl", 32'(flags_o), 32'hA);
        halt_seq(32'hE6000010, 32'h20);
`else
        halt_seq(32'hEB000002, 32'h10);
`endif

        pulse_reset();
        halt_seq(32'hE6000010, 32'h00);
        pulse_reset();
        @(negedge clk);
        chk("refetch_req", 32'(imem_req_o), 32'd1);
        chk("refetch_addr", 32'(imem_addr_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
